shift_unit: RTL

Parametrised successor to the experiment-6 shift register. It holds a WIDTH-bit register and executes one command per `i_start`: clear, load, logical/arithmetic shifts, serial-in shift, and rotates. Shift commands move the register's own contents by a programmable amount (0..WIDTH-1), iteratively one position per clock, or in a single clock when the barrel option is compiled in. It sits between the switch/button input logic and the LED/seven-segment display, and reports progress through a busy/done handshake.

---
 rtl/shift_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shift_unit.sv
// WIDTH-bit command-driven shift register: clear, load, shifts, serial-in and rotates.
// Define SHIFT_UNIT_BARREL_EN to finish every shift in one clock instead of one position per clock.
module shift_unit #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [AW-1:0]    i_amt,
  input  logic [WIDTH-1:0] i_num,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sout
);

  localparam logic [2:0] MODE_CLR  = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_LSR  = 3'b010;
  localparam logic [2:0] MODE_LSL  = 3'b011;
  localparam logic [2:0] MODE_ASR  = 3'b100;
  localparam logic [2:0] MODE_SIN  = 3'b101;
  localparam logic [2:0] MODE_ROR  = 3'b110;
  localparam logic [2:0] MODE_ROL  = 3'b111;
  localparam logic [AW-1:0] ONE    = 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [AW-1:0]    r_cnt;
  logic [2:0]       r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_sout;

  logic [2:0]       w_mode;
  logic [WIDTH-1:0] w_stepQ;
  logic             w_stepSout;

  // While shifting, the latched mode drives the datapath so live i_mode changes are ignored.
  assign w_mode = (r_state == S_IDLE) ? i_mode : r_mode;

  always_comb begin
    w_stepQ    = r_q;
    w_stepSout = r_q[0];
    case (w_mode)
      MODE_LSR: w_stepQ = {1'b0, r_q[WIDTH-1:1]};
      MODE_ASR: w_stepQ = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      MODE_SIN: w_stepQ = {i_sin, r_q[WIDTH-1:1]};
      MODE_ROR: w_stepQ = {r_q[0], r_q[WIDTH-1:1]};
      MODE_LSL: begin
        w_stepQ    = {r_q[WIDTH-2:0], 1'b0};
        w_stepSout = r_q[WIDTH-1];
      end
      MODE_ROL: begin
        w_stepQ    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_stepSout = r_q[WIDTH-1];
      end
      default: w_stepQ = r_q;
    endcase
  end

`ifdef SHIFT_UNIT_BARREL_EN
  logic [WIDTH-1:0]   w_barQ;
  logic               w_barSout;
  logic [2*WIDTH-1:0] w_rorWide;
  logic [2*WIDTH-1:0] w_rolWide;
  logic [WIDTH-1:0]   w_fill;

  // Rotates come from a doubled copy of Q; the fill mask covers the top i_amt bits for SIN.
  always_comb begin
    w_rorWide = {r_q, r_q} >> i_amt;
    w_rolWide = {r_q, r_q} << i_amt;
    w_fill    = ~({WIDTH{1'b1}} >> i_amt);
    w_barQ    = r_q;
    w_barSout = r_q[i_amt - ONE];
    case (i_mode)
      MODE_LSR: w_barQ = r_q >> i_amt;
      MODE_ASR: w_barQ = $unsigned($signed(r_q) >>> i_amt);
      MODE_SIN: w_barQ = (r_q >> i_amt) | (i_sin ? w_fill : '0);
      MODE_ROR: w_barQ = w_rorWide[WIDTH-1:0];
      MODE_LSL: begin
        w_barQ    = r_q << i_amt;
        w_barSout = r_q[-i_amt];
      end
      MODE_ROL: begin
        w_barQ    = w_rolWide[2*WIDTH-1:WIDTH];
        w_barSout = r_q[-i_amt];
      end
      default: w_barQ = r_q;
    endcase
  end
`endif

  // Command FSM: accept in IDLE, iterate in SHIFT; done is a registered one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_CLR;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode <= i_mode;
            if (i_mode == MODE_CLR || i_mode == MODE_LOAD) begin
              r_q    <= (i_mode == MODE_LOAD) ? i_num : '0;
              r_sout <= 1'b0;
              r_done <= 1'b1;
            end else if (i_amt == '0) begin
              r_done <= 1'b1;
            end else begin
`ifdef SHIFT_UNIT_BARREL_EN
              r_q    <= w_barQ;
              r_sout <= w_barSout;
              r_done <= 1'b1;
`else
              r_q    <= w_stepQ;
              r_sout <= w_stepSout;
              if (i_amt == ONE) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_SHIFT;
                r_busy  <= 1'b1;
                r_cnt   <= i_amt - ONE;
              end
`endif
            end
          end
        end
        S_SHIFT: begin
          r_q    <= w_stepQ;
          r_sout <= w_stepSout;
          r_cnt  <= r_cnt - ONE;
          if (r_cnt == ONE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Q    = r_q;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sout = r_sout;

endmodule
